rx_packet_ctrl: RTL and testbench

Receive-side control unit that sequences the bit-timing block (sample/shift/byte timer) through one packet. It enables and clears the timer, checks the SYNC and PID bytes, and pushes each data byte into the RX FIFO. It also detects a well-formed EOP and flags framing, PID and overflow errors. It sits between the edge/EOP detectors and the timer, shift register and RX FIFO.

---
 rtl/rx_packet_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_rx_packet_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_ctrl.sv
// rx_packet_ctrl
//   Receive-side packet sequencer. Drives the bit-timing block (count enable
//   and clear), checks the SYNC and PID bytes, pushes each data byte into the
//   RX FIFO, recognises a well-formed end of packet and flags framing, PID and
//   overflow errors.
//
// Ports
//   clk            system clock
//   n_rst          asynchronous active-low reset
//   d_edge         one-cycle pulse on any bus transition
//   eop            SE0 level (held for at least two bit periods)
//   shift_enable   one-cycle pulse per received bit
//   byte_received  one-cycle pulse after the 8th bit of a byte
//   rcv_data       shift-register contents
//   rcving         count enable to the timer
//   timer_clear    synchronous clear to the timer
//   w_enable       one-cycle FIFO push of rcv_data
//   pid            latched packet PID
//   pid_valid      pid holds a checked value
//   r_error        sticky error flag, cleared at the next packet start
//   rx_done        one-cycle pulse when a good packet completes
//   byte_count     data bytes stored in the current/last packet
module rx_packet_ctrl #(
  parameter logic [7:0]  SYNC_BYTE = 8'h80,
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             d_edge,
  input  logic                             eop,
  input  logic                             shift_enable,
  input  logic                             byte_received,
  input  logic [7:0]                       rcv_data,
  output logic                             rcving,
  output logic                             timer_clear,
  output logic                             w_enable,
  output logic [3:0]                       pid,
  output logic                             pid_valid,
  output logic                             r_error,
  output logic                             rx_done,
  output logic [$clog2(MAX_BYTES+1)-1:0]   byte_count
);

  localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  typedef enum logic [3:0] {
    IDLE,
    SYNC_RCV,
    SYNC_CHK,
    PID_RCV,
    PID_CHK,
    DATA_RCV,
    STORE,
    EOP_WAIT,
    DONE,
    ERR_EOP,
    ERR_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic             pid_valid_q, pid_valid_d;
  logic             r_error_q, r_error_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;

  logic pkt_start;
  logic pid_ok;
  logic sync_ok;
  logic fifo_full;

  assign pkt_start = (state_q == IDLE) && d_edge;
  assign sync_ok   = (rcv_data == SYNC_BYTE);
  assign pid_ok    = (rcv_data[3:0] == ~rcv_data[7:4]);
  assign fifo_full = (byte_count_q == MAX_CNT);

  // Next-state logic. eop is a level, so ignoring it in the one-cycle check
  // states loses nothing: it is seen again in the state that follows.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (d_edge) state_d = SYNC_RCV;
      SYNC_RCV: begin
        if (byte_received)  state_d = SYNC_CHK;
        else if (eop)       state_d = ERR_IDLE;
      end
      SYNC_CHK: state_d = sync_ok ? PID_RCV : ERR_EOP;
      PID_RCV: begin
        if (byte_received)  state_d = PID_CHK;
        else if (eop)       state_d = ERR_IDLE;
      end
      PID_CHK:  state_d = pid_ok ? DATA_RCV : ERR_EOP;
      DATA_RCV: begin
        if (byte_received)        state_d = STORE;
        else if (eop) begin
          // EOP is only well formed when it lands on a byte boundary.
          if (bit_cnt_q == 3'd0)  state_d = EOP_WAIT;
          else                    state_d = ERR_IDLE;
        end
      end
      STORE:    state_d = fifo_full ? ERR_EOP : DATA_RCV;
      EOP_WAIT: if (d_edge) state_d = DONE;
      DONE:     state_d = IDLE;
      ERR_EOP:  if (eop) state_d = ERR_IDLE;
      ERR_IDLE: if (d_edge && !eop) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Packet bookkeeping. Status from the previous packet is held until the
  // edge that starts the next one.
  always_comb begin
    pid_d        = pid_q;
    pid_valid_d  = pid_valid_q;
    r_error_d    = r_error_q;
    byte_count_d = byte_count_q;
    bit_cnt_d    = bit_cnt_q;

    if (pkt_start) begin
      pid_valid_d  = 1'b0;
      r_error_d    = 1'b0;
      byte_count_d = '0;
      bit_cnt_d    = '0;
    end

    if ((state_q == PID_CHK) && pid_ok) begin
      pid_d       = rcv_data[3:0];
      pid_valid_d = 1'b1;
    end

    if (state_q == DATA_RCV) begin
      if (byte_received)     bit_cnt_d = '0;
      else if (shift_enable) bit_cnt_d = bit_cnt_q + 3'd1;
    end

    if ((state_q == STORE) && !fifo_full) begin
      byte_count_d = byte_count_q + CNT_W'(1);
    end

    // Registered on entry so the flag is already high in both error states.
    if ((state_d == ERR_EOP) || (state_d == ERR_IDLE)) begin
      r_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      pid_q        <= '0;
      pid_valid_q  <= 1'b0;
      r_error_q    <= 1'b0;
      byte_count_q <= '0;
      bit_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pid_q        <= pid_d;
      pid_valid_q  <= pid_valid_d;
      r_error_q    <= r_error_d;
      byte_count_q <= byte_count_d;
      bit_cnt_q    <= bit_cnt_d;
    end
  end

  // Moore outputs, decoded purely from registered state.
  always_comb begin
    rcving      = 1'b0;
    timer_clear = 1'b0;
    w_enable    = 1'b0;
    rx_done     = 1'b0;
    unique case (state_q)
      SYNC_RCV, SYNC_CHK, PID_RCV, PID_CHK, DATA_RCV: rcving = 1'b1;
      STORE: begin
        rcving   = 1'b1;
        w_enable = !fifo_full;
      end
      IDLE, EOP_WAIT, ERR_EOP, ERR_IDLE: timer_clear = 1'b1;
      DONE: begin
        timer_clear = 1'b1;
        rx_done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign pid        = pid_q;
  assign pid_valid  = pid_valid_q;
  assign r_error    = r_error_q;
  assign byte_count = byte_count_q;

  a_wen_not_done: assert property (@(posedge clk) disable iff (!n_rst)
    !(w_enable && rx_done));
  a_count_bounded: assert property (@(posedge clk) disable iff (!n_rst)
    byte_count_q <= MAX_CNT);

endmodule

// File: tb/tb_rx_packet_ctrl.sv
module tb_rx_packet_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_edge, eop, shift_enable, byte_received;
  logic [7:0] rcv_data;
  logic       rcving, timer_clear, w_enable, pid_valid, r_error, rx_done;
  logic [3:0] pid;
  logic [1:0] byte_count;

  int n_vec  = 0;
  int n_miss = 0;
  int wen_cnt  = 0;
  int done_cnt = 0;
  logic [7:0] wdata [$];

  always #5 clk = ~clk;

  rx_packet_ctrl #(.SYNC_BYTE(8'h80), .MAX_BYTES(2)) dut (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
    .shift_enable(shift_enable), .byte_received(byte_received),
    .rcv_data(rcv_data), .rcving(rcving), .timer_clear(timer_clear),
    .w_enable(w_enable), .pid(pid), .pid_valid(pid_valid),
    .r_error(r_error), .rx_done(rx_done), .byte_count(byte_count)
  );

  always @(negedge clk) begin
    if (w_enable) begin
      wen_cnt++;
      wdata.push_back(rcv_data);
    end
    if (rx_done) done_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_edge();
    d_edge = 1'b1;
    cyc(1);
    d_edge = 1'b0;
  endtask

  task automatic shift_bits(input int n);
    for (int i = 0; i < n; i++) begin
      shift_enable = 1'b1;
      cyc(1);
      shift_enable = 1'b0;
      cyc(2);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    shift_bits(8);
    rcv_data      = b;
    byte_received = 1'b1;
    cyc(1);
    byte_received = 1'b0;
    cyc(3);
  endtask

  // EOP on a byte boundary followed by the J edge.
  task automatic finish_good();
    eop = 1'b1;
    cyc(3);
    eop    = 1'b0;
    pulse_edge();
    cyc(2);
  endtask

  // Leave an error state: EOP, then J edge with eop low.
  task automatic leave_error();
    eop = 1'b1;
    cyc(3);
    eop = 1'b0;
    pulse_edge();
    cyc(2);
  endtask

  initial begin
    n_rst = 1'b0; d_edge = 1'b0; eop = 1'b0;
    shift_enable = 1'b0; byte_received = 1'b0; rcv_data = 8'h00;
    cyc(2);
    check_val("rst_rcving",  rcving, 0);
    check_val("rst_tclear",  timer_clear, 1);
    check_val("rst_pid",     pid, 0);
    check_val("rst_pidv",    pid_valid, 0);
    check_val("rst_rerr",    r_error, 0);
    check_val("rst_bcnt",    byte_count, 0);
    n_rst = 1'b1;
    cyc(2);

    // 1: good packet
    pulse_edge();
    check_val("t1_rcving", rcving, 1);
    send_byte(8'h80);
    send_byte(8'hC3);
    check_val("t1_pid",  pid, 4'h3);
    check_val("t1_pidv", pid_valid, 1);
    send_byte(8'h12);
    send_byte(8'h34);
    eop = 1'b1;
    cyc(1);
    check_val("t1_eopw_tclear", timer_clear, 1);
    check_val("t1_eopw_rcving", rcving, 0);
    cyc(2);
    check_val("t1_nodone_yet", done_cnt, 0);
    eop = 1'b0;
    pulse_edge();
    cyc(2);
    check_val("t1_wen",   wen_cnt, 2);
    check_val("t1_d0",    wdata[0], 8'h12);
    check_val("t1_d1",    wdata[1], 8'h34);
    check_val("t1_bcnt",  byte_count, 2);
    check_val("t1_done",  done_cnt, 1);
    check_val("t1_rerr",  r_error, 0);
    check_val("t1_pidv2", pid_valid, 1);

    // 2: bad SYNC
    pulse_edge();
    send_byte(8'h81);
    check_val("t2_rerr",   r_error, 1);
    check_val("t2_rcving", rcving, 0);
    check_val("t2_wen",    wen_cnt, 2);
    leave_error();
    check_val("t2_idle_rerr",   r_error, 1);
    check_val("t2_idle_tclear", timer_clear, 1);
    pulse_edge();
    check_val("t2_start_rerr", r_error, 0);
    check_val("t2_start_bcnt", byte_count, 0);
    check_val("t2_start_pidv", pid_valid, 0);

    // 3: bad PID (continues the packet just started)
    send_byte(8'h80);
    send_byte(8'hC4);
    check_val("t3_rerr", r_error, 1);
    check_val("t3_pidv", pid_valid, 0);
    leave_error();
    check_val("t3_wen",  wen_cnt, 2);
    check_val("t3_done", done_cnt, 1);

    // 4: EOP mid-byte
    pulse_edge();
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'h5A);
    shift_bits(3);
    eop = 1'b1;
    cyc(1);
    check_val("t4_rerr",   r_error, 1);
    check_val("t4_rcving", rcving, 0);
    check_val("t4_bcnt",   byte_count, 1);
    check_val("t4_wen",    wen_cnt, 3);
    cyc(2);
    eop = 1'b0;
    pulse_edge();
    cyc(2);
    check_val("t4_bcnt_hold", byte_count, 1);
    check_val("t4_done",      done_cnt, 1);

    // 5: overflow at MAX_BYTES=2
    pulse_edge();
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    check_val("t5_wen",  wen_cnt, 5);
    check_val("t5_d3",   wdata[3], 8'hA1);
    check_val("t5_d4",   wdata[4], 8'hA2);
    check_val("t5_bcnt", byte_count, 2);
    check_val("t5_rerr", r_error, 1);
    leave_error();
    check_val("t5_done", done_cnt, 1);

    // 6: asynchronous reset during DATA_RCV with 5 bits in
    pulse_edge();
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'h66);
    shift_bits(5);
    #2 n_rst = 1'b0;
    #1;
    check_val("t6_rcving", rcving, 0);
    check_val("t6_tclear", timer_clear, 1);
    check_val("t6_pid",    pid, 0);
    check_val("t6_pidv",   pid_valid, 0);
    check_val("t6_bcnt",   byte_count, 0);
    check_val("t6_rerr",   r_error, 0);
    check_val("t6_wen_nb", w_enable, 0);
    cyc(2);
    n_rst = 1'b1;
    cyc(4);
    check_val("t6_wen_after",  wen_cnt, 6);
    check_val("t6_done_after", done_cnt, 1);
    pulse_edge();
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'h77);
    send_byte(8'h88);
    finish_good();
    check_val("t6_wen2",  wen_cnt, 8);
    check_val("t6_d6",    wdata[6], 8'h77);
    check_val("t6_d7",    wdata[7], 8'h88);
    check_val("t6_done2", done_cnt, 2);
    check_val("t6_pid2",  pid, 4'h3);
    check_val("t6_bcnt2", byte_count, 2);
    check_val("t6_rerr2", r_error, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
